// File: rtl/fp_to_twos_decoder.sv
// Sequential float-to-linear expander: rebuilds F << E one shift per clock,
// applies the sign and returns a two's-complement sample over ready/valid.
module fp_to_twos_decoder #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [SIG_W-1:0] in_sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] d_out,
    output logic             busy
);

    // The largest significand shifted by the largest exponent must fit the output.
    if (OUT_W < SIG_W + (2 ** EXP_W)) begin : g_width_check
        $error("fp_to_twos_decoder: OUT_W must be >= SIG_W + 2**EXP_W");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t             state_r;
    logic [OUT_W-1:0]   mag_r;
    logic [EXP_W-1:0]   cnt_r;
    logic               sign_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [OUT_W-1:0]   d_out_r;

    // Negative zero folds to zero naturally: ~0 + 1 wraps to 0.
    function automatic logic [OUT_W-1:0] apply_sign(input logic neg, input logic [OUT_W-1:0] mag);
        logic [OUT_W-1:0] res;
        if (neg) begin
            res = ~mag + OUT_W'(1);
        end else begin
            res = mag;
        end
        return res;
    endfunction

    // Conversion FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            mag_r       <= '0;
            cnt_r       <= '0;
            sign_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            d_out_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        sign_r     <= in_sign;
                        mag_r      <= OUT_W'(in_sig);
                        cnt_r      <= in_exp;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_r != '0) begin
                        mag_r <= mag_r << 1;
                        cnt_r <= cnt_r - EXP_W'(1);
                    end else begin
                        state_r <= SIGN;
                    end
                end
                SIGN: begin
                    d_out_r     <= apply_sign(sign_r, mag_r);
                    out_valid_r <= 1'b1;
                    state_r     <= HOLD;
                end
                HOLD: begin
                    // Freshly ready IDLE only accepts on the following edge.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign d_out     = d_out_r;

endmodule

// File: tb/tb_fp_to_twos_decoder.sv
// Directed bench for fp_to_twos_decoder: hand-computed vectors, latency,
// backpressure and mid-conversion reset.
module tb_fp_to_twos_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [2:0]  in_exp;
    logic [3:0]  in_sig;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] d_out;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    fp_to_twos_decoder #(.EXP_W(3), .SIG_W(4), .OUT_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_sig    (in_sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d_out     (d_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accept one float, measure edges to out_valid, check result, then drain.
    task automatic convert(input string tag, input logic s, input logic [2:0] e,
                           input logic [3:0] f, input logic [11:0] exp_d);
        int n;
        in_sign  = s;
        in_exp   = e;
        in_sig   = f;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_sign  = 1'b0;
        in_exp   = 3'd0;
        in_sig   = 4'd0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, e + 2);
        check({tag, "_d_out"}, {20'd0, d_out}, {20'd0, exp_d});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_drained"}, {29'd0, out_valid, in_ready, busy}, {29'd0, 3'b010});
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 3'd0;
        in_sig    = 4'd0;
        out_ready = 1'b0;
        step();
        step();
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_d_out", {20'd0, d_out}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        step();

        convert("t1_e0_f5",   1'b0, 3'd0, 4'd5,  12'h005);
        convert("t2_e7_f15",  1'b0, 3'd7, 4'd15, 12'h780);
        convert("t3_neg72",   1'b1, 3'd3, 4'd9,  12'hFB8);
        convert("t4_negzero", 1'b1, 3'd4, 4'd0,  12'h000);
        convert("t_neg1920",  1'b1, 3'd7, 4'd15, 12'h880);
        convert("t_e2_f1",    1'b0, 3'd2, 4'd1,  12'h004);

        // Backpressure: 3<<1 = 6 held while a new input waits.
        in_sign  = 1'b0;
        in_exp   = 3'd1;
        in_sig   = 4'd3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("bp_latency", n, 32'd3);
        in_sign  = 1'b0;
        in_exp   = 3'd0;
        in_sig   = 4'd7;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_d_out", {20'd0, d_out}, 32'h006);
            check("bp_hold_flags", {30'd0, out_valid, in_ready}, 32'b10);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_release", {29'd0, out_valid, in_ready, busy}, {29'd0, 3'b010});
        step();
        check("bp_accept_next", {30'd0, busy, in_ready}, 32'b10);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("bp_next_latency", n, 32'd2);
        check("bp_next_d_out", {20'd0, d_out}, 32'h007);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset pulse while shifting E=6: result must be discarded.
        in_sign  = 1'b0;
        in_exp   = 3'd6;
        in_sig   = 4'd1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rst_mid_flags", {29'd0, out_valid, in_ready, busy}, {29'd0, 3'b010});
        check("rst_mid_d_out", {20'd0, d_out}, 32'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid || busy) n++;
        end
        check("rst_no_stale", n, 32'd0);
        check("rst_d_out_still_zero", {20'd0, d_out}, 32'd0);

        convert("post_rst", 1'b1, 3'd1, 4'd1, 12'hFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
